// File: rtl/ace_instbuf_if.sv
// Fetch/decode-side signal bundle for the decode stage 0 instruction buffer.
interface ace_instbuf_if #(
  parameter int unsigned PTR_W = 5
);
  logic             flush_rt_i;
  logic             fetch_wr_vld_i;
  logic             inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i;
  logic             inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i;
  logic [31:0]      inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i;
  logic [31:0]      inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i;
  logic [2:0]       dec_take_i;
  logic [3:0]       dec_vld_o;
  logic [31:0]      dec_inst0_o, dec_inst1_o, dec_inst2_o, dec_inst3_o;
  logic [PTR_W:0]   instbuf_cnt_o;
  logic             instbuf_full_o;

  modport slave (
    input  flush_rt_i, fetch_wr_vld_i,
    input  inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
    input  inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
    input  inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
    input  inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
    input  dec_take_i,
    output dec_vld_o, dec_inst0_o, dec_inst1_o, dec_inst2_o, dec_inst3_o,
    output instbuf_cnt_o, instbuf_full_o
  );

  modport master (
    output flush_rt_i, fetch_wr_vld_i,
    output inst0_vld_d0_i, inst1_vld_d0_i, inst2_vld_d0_i, inst3_vld_d0_i,
    output inst4_vld_d0_i, inst5_vld_d0_i, inst6_vld_d0_i, inst7_vld_d0_i,
    output inst0_d0_i, inst1_d0_i, inst2_d0_i, inst3_d0_i,
    output inst4_d0_i, inst5_d0_i, inst6_d0_i, inst7_d0_i,
    output dec_take_i,
    input  dec_vld_o, dec_inst0_o, dec_inst1_o, dec_inst2_o, dec_inst3_o,
    input  instbuf_cnt_o, instbuf_full_o
  );
endinterface

// File: rtl/ace_instbuf.sv
// Decode stage 0 instruction buffer: compacts valid fetch slots into a
// circular FIFO and presents the four oldest entries to decode.
module ace_instbuf #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned FETCH_W = 8,
  parameter int unsigned DEC_W   = 4,
  parameter int unsigned PTR_W   = 5
) (
  input logic          clock,
  input logic          reset_n,
  ace_instbuf_if.slave ib
);
  localparam int unsigned CW = $clog2(FETCH_W + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W+1:0] cnt_sum;

  logic [FETCH_W-1:0] vld;
  logic [31:0]        word [FETCH_W];
  logic [CW-1:0]      ofs  [FETCH_W];
  logic [CW-1:0]      wcnt;
  logic [2:0]         take_eff;
  logic               wr_en;

  // Gather the slot-level fetch signals into arrays
  always_comb begin
    vld     = {ib.inst7_vld_d0_i, ib.inst6_vld_d0_i, ib.inst5_vld_d0_i, ib.inst4_vld_d0_i,
               ib.inst3_vld_d0_i, ib.inst2_vld_d0_i, ib.inst1_vld_d0_i, ib.inst0_vld_d0_i};
    word[0] = ib.inst0_d0_i;
    word[1] = ib.inst1_d0_i;
    word[2] = ib.inst2_d0_i;
    word[3] = ib.inst3_d0_i;
    word[4] = ib.inst4_d0_i;
    word[5] = ib.inst5_d0_i;
    word[6] = ib.inst6_d0_i;
    word[7] = ib.inst7_d0_i;
  end

  // Compaction offsets (prefix popcount), clipped take, next pointers/count
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < FETCH_W; j++) begin
      ofs[j] = acc;
      acc    = acc + CW'(vld[j]);
    end
    wcnt  = acc;
    wr_en = ib.fetch_wr_vld_i & ~ib.flush_rt_i;

    take_eff = ib.dec_take_i;
    if (take_eff > 3'(DEC_W)) take_eff = 3'(DEC_W);
    if ((PTR_W+1)'(take_eff) > cnt_q) take_eff = cnt_q[2:0];

    cnt_sum = {1'b0, cnt_q} - (PTR_W+2)'(take_eff) + (wr_en ? (PTR_W+2)'(wcnt) : '0);

    rd_ptr_d = rd_ptr_q + PTR_W'(take_eff);
    wr_ptr_d = wr_ptr_q + (wr_en ? PTR_W'(wcnt) : '0);
    cnt_d    = cnt_sum[PTR_W:0];
    if (ib.flush_rt_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Pointer/count state; reset outranks flush, flush outranks read/write
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (!ib.flush_rt_i) assert (cnt_sum <= (PTR_W+2)'(DEPTH));
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write: k-th valid slot lands at wr_ptr+k, wrapping naturally
  always_ff @(posedge clock) begin
    if (reset_n && wr_en) begin
      for (int unsigned j = 0; j < FETCH_W; j++) begin
        if (vld[j]) mem_q[wr_ptr_q + PTR_W'(ofs[j])] <= word[j];
      end
    end
  end

  // Decode-facing outputs, flags from the registered count only
  always_comb begin
    ib.dec_inst0_o = mem_q[rd_ptr_q];
    ib.dec_inst1_o = mem_q[rd_ptr_q + PTR_W'(1)];
    ib.dec_inst2_o = mem_q[rd_ptr_q + PTR_W'(2)];
    ib.dec_inst3_o = mem_q[rd_ptr_q + PTR_W'(3)];
    for (int unsigned k = 0; k < 4; k++) begin
      ib.dec_vld_o[k] = (cnt_q > (PTR_W+1)'(k));
    end
    ib.instbuf_cnt_o  = cnt_q;
    ib.instbuf_full_o = (cnt_q > (PTR_W+1)'(DEPTH - 2*FETCH_W));
  end
endmodule

// File: tb/tb_ace_instbuf.sv
// Directed + randomized bench for ace_instbuf against a queue-based model.
module tb_ace_instbuf;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  mask;
  logic [31:0] words [8];
  logic        wr, flush;
  logic [2:0]  take;
  logic [31:0] dout [4];
  logic [31:0] q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          peak  = 0;
  logic        loaded;

  ace_instbuf_if #(.PTR_W(5)) ifc ();

  ace_instbuf #(.DEPTH(32), .FETCH_W(8), .DEC_W(4), .PTR_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ib      (ifc)
  );

  always #5 clock = ~clock;

  assign ifc.flush_rt_i     = flush;
  assign ifc.fetch_wr_vld_i = wr;
  assign ifc.dec_take_i     = take;
  assign ifc.inst0_vld_d0_i = mask[0];
  assign ifc.inst1_vld_d0_i = mask[1];
  assign ifc.inst2_vld_d0_i = mask[2];
  assign ifc.inst3_vld_d0_i = mask[3];
  assign ifc.inst4_vld_d0_i = mask[4];
  assign ifc.inst5_vld_d0_i = mask[5];
  assign ifc.inst6_vld_d0_i = mask[6];
  assign ifc.inst7_vld_d0_i = mask[7];
  assign ifc.inst0_d0_i = words[0];
  assign ifc.inst1_d0_i = words[1];
  assign ifc.inst2_d0_i = words[2];
  assign ifc.inst3_d0_i = words[3];
  assign ifc.inst4_d0_i = words[4];
  assign ifc.inst5_d0_i = words[5];
  assign ifc.inst6_d0_i = words[6];
  assign ifc.inst7_d0_i = words[7];
  assign dout[0] = ifc.dec_inst0_o;
  assign dout[1] = ifc.dec_inst1_o;
  assign dout[2] = ifc.dec_inst2_o;
  assign dout[3] = ifc.dec_inst3_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model queue
  task automatic check_all(input string tag);
    int sz;
    logic [3:0] ev;
    sz = q.size();
    ev = '0;
    for (int k = 0; k < 4; k++) if (sz > k) ev[k] = 1'b1;
    chk({tag, ".cnt"},  32'(ifc.instbuf_cnt_o), 32'(sz));
    chk({tag, ".full"}, 32'(ifc.instbuf_full_o), 32'(sz > 16));
    chk({tag, ".vld"},  32'(ifc.dec_vld_o), 32'(ev));
    for (int k = 0; k < 4; k++) begin
      if (k < sz) chk($sformatf("%s.inst%0d", tag, k), dout[k], q[k]);
    end
  endtask

  // One clock edge; model applies the rules to the inputs held across it
  task automatic step();
    int te;
    @(posedge clock);
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      te = int'(take);
      if (te > 4) te = 4;
      if (te > q.size()) te = q.size();
      repeat (te) void'(q.pop_front());
      if (wr) for (int s = 0; s < 8; s++) if (mask[s]) q.push_back(words[s]);
    end
    #1;
    if (int'(ifc.instbuf_cnt_o) > peak) peak = int'(ifc.instbuf_cnt_o);
  endtask

  task automatic idle();
    wr = 1'b0; flush = 1'b0; take = 3'd0; mask = 8'h00;
  endtask

  task automatic set_b(input logic [7:0] m, input logic [31:0] base);
    mask = m;
    for (int s = 0; s < 8; s++) words[s] = base + 32'(s);
  endtask

  initial begin
    idle();
    set_b(8'h00, 32'h0);
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_all("reset");

    // 1: full bundle, then take 4
    set_b(8'hFF, 32'h100); wr = 1'b1;
    step(); idle();
    check_all("t1.wr");
    chk("t1.inst0", dout[0], 32'h100);
    take = 3'd4;
    step(); idle();
    check_all("t1.take");
    chk("t1.inst0b", dout[0], 32'h104);
    take = 3'd4; step(); idle();
    check_all("t1.drain");

    // 2: sparse mask, then concurrent take 2 + write
    set_b(8'b1010_0101, 32'h0); wr = 1'b1;
    step(); idle();
    check_all("t2.wr");
    set_b(8'h03, 32'h10); wr = 1'b1; take = 3'd2;
    step(); idle();
    check_all("t2.rw");
    chk("t2.o0", dout[0], 32'h5);
    chk("t2.o1", dout[1], 32'h7);
    chk("t2.o2", dout[2], 32'h10);
    chk("t2.o3", dout[3], 32'h11);
    take = 3'd4; step(); idle();
    check_all("t2.drain");

    // 3: back-to-back bundles obeying the registered full back-pressure
    loaded = 1'b0;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      set_b(8'hFF, 32'h300 + 32'(8*i));
      wr = loaded;
      loaded = (q.size() <= 16);
      step();
      check_all($sformatf("t3.c%0d", i));
    end
    idle();
    chk("t3.peak", 32'(peak), 32'd32);
    flush = 1'b1; step(); idle();
    check_all("t3.flush");

    // 4: advance pointers to 28, then a bundle that wraps
    for (int i = 0; i < 7; i++) begin
      set_b(8'h0F, 32'h200 + 32'(4*i)); wr = 1'b1; take = 3'd4;
      step();
    end
    idle(); take = 3'd4; step(); idle();
    check_all("t4.pre");
    set_b(8'hFF, 32'h400); wr = 1'b1;
    step(); idle();
    check_all("t4.wr");
    chk("t4.inst0", dout[0], 32'h400);
    take = 3'd4; step(); idle();
    check_all("t4.take1");
    chk("t4.inst0b", dout[0], 32'h404);
    take = 3'd4; step(); idle();
    check_all("t4.take2");

    // 5: flush with cnt=20 beats write+take
    set_b(8'hFF, 32'h500); wr = 1'b1; step();
    set_b(8'hFF, 32'h508); step();
    set_b(8'h0F, 32'h510); step(); idle();
    check_all("t5.pre");
    set_b(8'hFF, 32'h520); wr = 1'b1; take = 3'd4; flush = 1'b1;
    step(); idle();
    check_all("t5.flush");
    set_b(8'h01, 32'h530); wr = 1'b1;
    step(); idle();
    check_all("t5.after");

    // 6: over-take, empty take, mid-stream reset
    flush = 1'b1; step(); idle();
    set_b(8'h03, 32'h600); wr = 1'b1; step(); idle();
    check_all("t6.two");
    take = 3'd4; step(); idle();
    check_all("t6.over");
    take = 3'd3; step(); idle();
    check_all("t6.empty");
    set_b(8'hFF, 32'h610); wr = 1'b1; step(); idle();
    check_all("t6.after");
    set_b(8'hFF, 32'h620); wr = 1'b1; step();
    reset_n = 1'b0; step(); reset_n = 1'b1; idle();
    check_all("t6.reset");

    // Randomized traffic with legal back-pressure
    for (int i = 0; i < 400; i++) begin
      mask = 8'($urandom);
      for (int s = 0; s < 8; s++) words[s] = $urandom;
      wr    = ($urandom_range(0, 3) != 0) && (q.size() <= 24);
      take  = 3'($urandom_range(0, 4));
      flush = ($urandom_range(0, 63) == 0);
      reset_n = ($urandom_range(0, 127) != 0);
      step();
      reset_n = 1'b1;
      check_all($sformatf("rnd%0d", i));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
